nn_mac_stage: RTL
=================

# nn_mac_stage

Downstream consumer of the 8-deep, 32-bit input FIFO in the Wishbone neural-net accelerator. It drains a fixed-length vector of activations from the FIFO and multiply-accumulates it against a locally stored weight vector. It adds a bias, optionally applies ReLU, and saturates the sum to 32 bits. The result is presented on a valid/ready port for the Wishbone readback logic.

## Interface
- `N_INPUTS`, 8: activations per neuron evaluation; weight bank depth; must be ≥1.
- `AW`, `$clog2(N_INPUTS)` (min 1): weight address width.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  begin one evaluation; honoured only in IDLE.
- `fifo_rd_o`  out  1  pop request; drives FIFO `ce` with `we`=0.
- `fifo_data_i`  in  32  FIFO `data_o`; activation = signed `[15:0]`, `[31:16]` ignored.
- `w_we_i`  in  1  weight write strobe.
- `w_addr_i`  in  AW  weight index.
- `w_data_i`  in  16  signed weight.
- `b_we_i`  in  1  bias write strobe.
- `b_data_i`  in  32  signed bias.
- `busy_o`  out  1  high in every state except IDLE.
- `result_valid_o`  out  1  result available.
- `result_ready_i`  in  1  consumer accepts result.
- `result_o`  out  32  signed result.

## Operation
- States: IDLE, ACCUM, FINISH, OUT.
- IDLE: `start_i`=1 → clear accumulator and index, go to ACCUM.
- ACCUM: `fifo_rd_o`=1 every cycle. `acc += sext(fifo_data_i[15:0]) * w[idx]` (signed 16x16 → 32). `idx++`. After the cycle with `idx==N_INPUTS-1` → FINISH.
- FINISH: `acc += sext(bias)`. Apply the ReLU per Configuration. Saturate to [-2^31, 2^31-1]. Register into `result_o`. → OUT.
- OUT: `result_valid_o`=1 and `result_o` held stable until `result_valid_o && result_ready_i`; the next state is then IDLE.
- Accumulator width `ACC_W = 33 + $clog2(N_INPUTS)`. Products and the bias are sign-extended to ACC_W, so no wrap before saturation.
- Caller precondition: the FIFO holds ≥N_INPUTS words when `start_i` is asserted. No empty detection exists; underrun reads stale FIFO data.
- Weight/bias writes take effect in IDLE only and are ignored when `busy_o`=1. A write and `start_i` in the same IDLE cycle: the write lands and the evaluation uses the new value.
- `start_i` outside IDLE is ignored (not queued).
- Out-of-range `w_addr_i` (≥N_INPUTS) writes are dropped.

## Timing
- Reset values: `fifo_rd_o`=0, `busy_o`=0, `result_valid_o`=0, `result_o`=0, all weights and bias=0, state IDLE, accumulator=0.
- `start_i` sampled at edge T. `fifo_rd_o` is high for exactly N_INPUTS cycles, T+1..T+N.
- Each activation is consumed combinationally in the same cycle that `fifo_rd_o` is high. The FIFO pops on that edge.
- FINISH occupies cycle T+N+1. `result_valid_o` rises at T+N+2.
- Latency from start to valid is N_INPUTS+2 cycles. Minimum start-to-start period is N_INPUTS+3 cycles.
- Reset mid-operation clears immediately (asynchronous). `fifo_rd_o` drops without waiting for a clock edge. Partial FIFO pops already taken are not undone.

## Configuration
- `NN_MAC_RELU_EN` defined: in FINISH, a negative post-bias sum becomes 0 before saturation. `result_o` is never negative.
- Not defined: the signed post-bias sum passes through to saturation. Negative results are reported in two's complement.

## Test plan
- Weights all 1, bias 0, FIFO preloaded 1..8, start → `fifo_rd_o` high 8 cycles; `result_valid_o` at T+10 with `result_o`=36.
- Weights all -1, inputs 1..8, bias 0 → with `NN_MAC_RELU_EN` `result_o`=0. Without it, `result_o`=0xFFFFFFDC (-36).
- Weights 0x7FFF, inputs 0x7FFF, bias 0x7FFFFFFF → `result_o`=0x7FFFFFFF. No ReLU, weights 0x8000, inputs 0x7FFF, bias 0x80000000 → `result_o`=0x80000000.
- Backpressure: `result_ready_i`=0 for 5 cycles after valid → `result_o` and `result_valid_o` stable. Ready=1 → valid low next cycle, `busy_o`=0.
- Assert `rst` after 3 pops → all outputs 0 immediately, weights 0. A new run with weights reloaded matches the expected result.
- `start_i` and `w_we_i` pulsed while busy → no second run; the weight is unchanged (readback via a subsequent evaluation).

Source files
------------

// File: rtl/nn_mac_stage.sv
// nn_mac_stage
//   Drains N_INPUTS activations from the upstream 32-bit FIFO and multiply-
//   accumulates them against a local signed 16-bit weight bank. It then adds a
//   signed 32-bit bias, optionally applies ReLU, saturates to 32 bits, and
//   offers the result on a valid/ready port.
//
//   Build option: define NN_MAC_RELU_EN to clamp negative post-bias sums to 0.
//
// Ports
//   clk, rst           clock (posedge), asynchronous active-high reset
//   start_i            begin one evaluation (honoured in IDLE only)
//   fifo_rd_o          FIFO pop request, high for the N_INPUTS ACCUM cycles
//   fifo_data_i        FIFO word; [15:0] is the signed activation
//   w_we_i/w_addr_i/w_data_i   weight bank write port (IDLE only)
//   b_we_i/b_data_i    bias write port (IDLE only)
//   busy_o             high whenever not IDLE
//   result_valid_o / result_ready_i / result_o   result handshake
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start_i; weight/bias writes accepted
// ACCUM  | pop one activation per cycle and accumulate act * w[idx]
// FINISH | add bias, optional ReLU, saturate, register result_o
// OUT    | result_valid_o high until the consumer takes it
module nn_mac_stage #(
  parameter int N_INPUTS = 8,
  parameter int AW       = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  output logic          fifo_rd_o,
  input  logic [31:0]   fifo_data_i,
  input  logic          w_we_i,
  input  logic [AW-1:0] w_addr_i,
  input  logic [15:0]   w_data_i,
  input  logic          b_we_i,
  input  logic [31:0]   b_data_i,
  output logic          busy_o,
  output logic          result_valid_o,
  input  logic          result_ready_i,
  output logic [31:0]   result_o
);

  // 32-bit products plus headroom for N_INPUTS of them and the bias.
  localparam int ACC_W = 33 + $clog2(N_INPUTS);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_INPUTS - 1);
  localparam logic [AW:0]   N_LIM    = (AW+1)'(N_INPUTS);

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH, OUT} state_t;

  state_t state_q, state_d;

  logic [15:0]      w_q [N_INPUTS];
  logic [31:0]      bias_q;
  logic [ACC_W-1:0] acc_q;
  logic [AW-1:0]    idx_q;

  logic [31:0]      act_ext;
  logic [31:0]      w_ext;
  logic [31:0]      prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] bias_ext;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] post;
  logic [31:0]      sat;
  logic             fits_32;
  logic             unused_fifo_hi;

  assign unused_fifo_hi = ^fifo_data_i[31:16];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    fifo_rd_o      = 1'b0;
    busy_o         = 1'b1;
    result_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_d = ACCUM;
      end
      ACCUM: begin
        fifo_rd_o = 1'b1;
        if (idx_q == LAST_IDX) state_d = FINISH;
      end
      FINISH: state_d = OUT;
      OUT: begin
        result_valid_o = 1'b1;
        if (result_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------- arithmetic
  // Low 32 bits of a 32x32 product of sign-extended 16-bit operands equal
  // the exact signed 16x16 product.
  assign act_ext  = {{16{fifo_data_i[15]}}, fifo_data_i[15:0]};
  assign w_ext    = {{16{w_q[idx_q][15]}}, w_q[idx_q]};
  assign prod     = act_ext * w_ext;
  assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
  assign bias_ext = {{(ACC_W-32){bias_q[31]}}, bias_q};
  assign sum      = acc_q + bias_ext;

`ifdef NN_MAC_RELU_EN
  assign post = sum[ACC_W-1] ? '0 : sum;
`else
  assign post = sum;
`endif

  // The value fits in 32 bits when every bit from 31 upward matches the sign.
  assign fits_32 = (&post[ACC_W-1:31]) | ~(|post[ACC_W-1:31]);

  always_comb begin
    sat = post[31:0];
    if (!fits_32) sat = post[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      idx_q    <= '0;
      result_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            acc_q <= '0;
            idx_q <= '0;
          end
        end
        ACCUM: begin
          acc_q <= acc_q + prod_ext;
          idx_q <= idx_q + 1'b1;
        end
        FINISH:  result_o <= sat;
        default: ;
      endcase
    end
  end

  // Weight and bias storage; writes only land while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_INPUTS; i++) w_q[i] <= '0;
      bias_q <= '0;
    end else if (state_q == IDLE) begin
      if (w_we_i && ({1'b0, w_addr_i} < N_LIM)) w_q[w_addr_i] <= w_data_i;
      if (b_we_i) bias_q <= b_data_i;
    end
  end

endmodule
